// File: rtl/conv_window_sequencer.sv
// Sliding-window sequencer: streams (sample, weight) pairs for one 1D
// convolution channel into a single mult_reduce instance.
module conv_window_sequencer #(
    parameter int DATA_WIDTH    = 12,
    parameter int KERNEL_SIZE   = 5,
    parameter int SIGNAL_LENGTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           weight_wr_en,
    input  logic [$clog2(KERNEL_SIZE)-1:0] weight_wr_addr,
    input  logic [DATA_WIDTH-1:0]          weight_wr_data,
    output logic                           weight_wr_ready,
    input  logic                           window_seq_valid_in,
    output logic                           window_seq_ready_in,
    input  logic [DATA_WIDTH-1:0]          window_seq_data_in,
    output logic                           window_seq_valid_out,
    input  logic                           window_seq_ready_out,
    output logic [DATA_WIDTH-1:0]          window_seq_dataa_out,
    output logic [DATA_WIDTH-1:0]          window_seq_datab_out,
    output logic                           window_seq_frame_done
);
    localparam int KW = $clog2(KERNEL_SIZE);
    localparam int FW = $clog2(KERNEL_SIZE + 1);
    localparam int SW = $clog2(SIGNAL_LENGTH + 1);
    localparam logic [KW-1:0] K_LAST = KW'(KERNEL_SIZE - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW:0]   K_SIZE = (KW+1)'(KERNEL_SIZE);
    localparam logic [FW-1:0] F_LAST = FW'(KERNEL_SIZE - 1);
    localparam logic [FW-1:0] F_ONE  = FW'(1);
    localparam logic [SW-1:0] S_LEN  = SW'(SIGNAL_LENGTH);
    localparam logic [SW-1:0] S_ONE  = SW'(1);

    typedef enum logic [1:0] {FILL, ISSUE, SHIFT} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] window [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] window_nx [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] weight [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] weight_nx [KERNEL_SIZE];
    logic [KW-1:0]         k, k_nx;
    logic [FW-1:0]         fill_cnt, fill_nx;
    logic [SW-1:0]         smp_cnt, smp_nx;
    logic                  ready_in_nx, valid_nx, done_nx, wr_ready_nx;
    logic [DATA_WIDTH-1:0] dataa_nx, datab_nx;
    logic                  sample_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= FILL;
            k                     <= '0;
            fill_cnt              <= '0;
            smp_cnt               <= '0;
            window_seq_ready_in   <= 1'b1;
            window_seq_valid_out  <= 1'b0;
            window_seq_dataa_out  <= '0;
            window_seq_datab_out  <= '0;
            window_seq_frame_done <= 1'b0;
            weight_wr_ready       <= 1'b1;
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                window[i] <= '0;
                weight[i] <= '0;
            end
        end else begin
            state                 <= state_nx;
            k                     <= k_nx;
            fill_cnt              <= fill_nx;
            smp_cnt               <= smp_nx;
            window_seq_ready_in   <= ready_in_nx;
            window_seq_valid_out  <= valid_nx;
            window_seq_dataa_out  <= dataa_nx;
            window_seq_datab_out  <= datab_nx;
            window_seq_frame_done <= done_nx;
            weight_wr_ready       <= wr_ready_nx;
            window                <= window_nx;
            weight                <= weight_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        k_nx        = k;
        fill_nx     = fill_cnt;
        smp_nx      = smp_cnt;
        ready_in_nx = window_seq_ready_in;
        valid_nx    = window_seq_valid_out;
        dataa_nx    = window_seq_dataa_out;
        datab_nx    = window_seq_datab_out;
        done_nx     = 1'b0;
        window_nx   = window;
        weight_nx   = weight;
        sample_acc  = window_seq_valid_in && window_seq_ready_in;

        if (weight_wr_en && weight_wr_ready && ({1'b0, weight_wr_addr} < K_SIZE))
            weight_nx[weight_wr_addr] = weight_wr_data;

        // Newest sample enters at the top; index 0 always holds the oldest.
        if (sample_acc) begin
            for (int i = 0; i < KERNEL_SIZE - 1; i++)
                window_nx[i] = window[i+1];
            window_nx[KERNEL_SIZE-1] = window_seq_data_in;
            smp_nx = smp_cnt + S_ONE;
        end

        case (state)
            FILL: begin
                if (sample_acc) begin
                    fill_nx = fill_cnt + F_ONE;
                    if (fill_cnt == F_LAST) begin
                        state_nx    = ISSUE;
                        ready_in_nx = 1'b0;
                    end
                end
            end
            SHIFT: begin
                if (sample_acc) begin
                    state_nx    = ISSUE;
                    ready_in_nx = 1'b0;
                end
            end
            ISSUE: begin
                if (!window_seq_valid_out) begin
                    valid_nx = 1'b1;
                    dataa_nx = window[k];
                    datab_nx = weight[k];
                end else if (window_seq_ready_out) begin
                    if (k == K_LAST) begin
                        valid_nx    = 1'b0;
                        k_nx        = '0;
                        ready_in_nx = 1'b1;
                        if (smp_cnt == S_LEN) begin
                            done_nx  = 1'b1;
                            smp_nx   = '0;
                            fill_nx  = '0;
                            state_nx = FILL;
                        end else begin
                            state_nx = SHIFT;
                        end
                    end else begin
                        k_nx     = k + K_ONE;
                        dataa_nx = window[k + K_ONE];
                        datab_nx = weight[k + K_ONE];
                    end
                end
            end
            default: state_nx = FILL;
        endcase

        wr_ready_nx = (state_nx != ISSUE);
    end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: table-driven frames against a window
// model, plus hand sequences for weight writes and mid-frame reset.
module tb_conv_window_sequencer;
    localparam int DW = 12;
    localparam int K  = 5;
    localparam int SL = 32;
    localparam int NG = SL - K + 1;
    localparam int LIMIT = 3000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          weight_wr_en = 1'b0;
    logic [2:0]    weight_wr_addr = '0;
    logic [DW-1:0] weight_wr_data = '0;
    logic          weight_wr_ready;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [DW-1:0] data_in = '0;
    logic          valid_out;
    logic          ready_out = 1'b0;
    logic [DW-1:0] dataa, datab;
    logic          frame_done;

    conv_window_sequencer #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(K), .SIGNAL_LENGTH(SL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .weight_wr_en(weight_wr_en),
        .weight_wr_addr(weight_wr_addr),
        .weight_wr_data(weight_wr_data),
        .weight_wr_ready(weight_wr_ready),
        .window_seq_valid_in(valid_in),
        .window_seq_ready_in(ready_in),
        .window_seq_data_in(data_in),
        .window_seq_valid_out(valid_out),
        .window_seq_ready_out(ready_out),
        .window_seq_dataa_out(dataa),
        .window_seq_datab_out(datab),
        .window_seq_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            ready_mode;
        int            valid_pct;
        int            seq_kind;
        int            w_kind;
        bit            check_ends;
        logic [DW-1:0] fa, fb, la, lb;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;
    int stall_err;
    logic [DW-1:0] w_model [K];
    logic [DW-1:0] src[$], frame[$], got_a[$], got_b[$];
    int done_at[$], results[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic write_weight(input logic [2:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        weight_wr_en   = 1'b1;
        weight_wr_addr = a;
        weight_wr_data = d;
        @(negedge clk);
        weight_wr_en = 1'b0;
    endtask

    task automatic load_weights(input int kind);
        logic [DW-1:0] v;
        if (kind != 3) begin
            for (int i = 0; i < K; i++) begin
                if (kind == 0) v = DW'(i + 1);
                else if (kind == 1) v = DW'($urandom_range(4095));
                else v = 1;
                write_weight(3'(i), v);
                w_model[i] = v;
            end
        end
    endtask

    task automatic build_src(input int kind, input int base);
        logic [DW-1:0] v;
        src.delete();
        frame.delete();
        for (int i = 0; i < SL; i++) begin
            if (kind == 0) v = DW'(base + i + 1);
            else if (kind == 1) v = DW'($urandom_range(4095));
            else v = 2;
            src.push_back(v);
            frame.push_back(v);
        end
    endtask

    task automatic run_frame(input int ready_mode, input int valid_pct,
                             input int stop_at, input bit wr_in_issue);
        int cyc = 0;
        bit finished = 0;
        bit acc_s = 0;
        bit prev_stall = 0;
        bit injected = 0;
        bit mr_dead = 0;
        int mr_cnt = 0;
        int acc = 0;
        logic [DW-1:0] pa = '0, pb = '0;
        got_a.delete();
        got_b.delete();
        done_at.delete();
        results.delete();
        stall_err = 0;
        while (cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (acc_s) begin
                void'(src.pop_front());
                valid_in = 1'b0;
            end
            if (prev_stall && (!valid_out || dataa != pa || datab != pb))
                stall_err++;
            if (frame_done) done_at.push_back(got_a.size());
            if (frame_done || (stop_at > 0 && got_a.size() >= stop_at)) begin
                valid_in     = 1'b0;
                ready_out    = 1'b0;
                weight_wr_en = 1'b0;
                finished     = 1;
                break;
            end
            weight_wr_en = 1'b0;
            if (wr_in_issue && !injected && valid_out) begin
                weight_wr_en   = 1'b1;
                weight_wr_addr = 3'd2;
                weight_wr_data = 99;
                injected       = 1;
                check("wr_ready_in_issue", int'(weight_wr_ready), 0);
            end
            case (ready_mode)
                0: ready_out = 1'b1;
                1: ready_out = ~ready_out;
                2: ready_out = ($urandom_range(99) < 50);
                default: begin
                    ready_out = !mr_dead;
                    mr_dead   = 0;
                end
            endcase
            if (!valid_in && src.size() > 0 && $urandom_range(99) < valid_pct) begin
                valid_in = 1'b1;
                data_in  = src[0];
            end
            acc_s      = valid_in && ready_in;
            prev_stall = valid_out && !ready_out;
            pa = dataa;
            pb = datab;
            if (valid_out && ready_out) begin
                got_a.push_back(dataa);
                got_b.push_back(datab);
                if (ready_mode == 3) begin
                    acc += int'(dataa) * int'(datab);
                    mr_cnt++;
                    if (mr_cnt == K) begin
                        results.push_back(acc);
                        acc = 0;
                        mr_cnt = 0;
                        mr_dead = 1;
                    end
                end
            end
        end
        check("run_completed", int'(finished), 1);
    endtask

    task automatic check_frame(input string tag, input int mode);
        int bad = 0;
        int rbad = 0;
        int sum;
        check({tag, ":pair_count"}, got_a.size(), NG * K);
        for (int g = 0; g < NG; g++)
            for (int t = 0; t < K; t++)
                if (g * K + t < got_a.size())
                    if (got_a[g*K+t] != frame[g+t] || got_b[g*K+t] != w_model[t])
                        bad++;
        check({tag, ":pair_errors"}, bad, 0);
        check({tag, ":done_count"}, done_at.size(), 1);
        if (done_at.size() > 0)
            check({tag, ":done_position"}, done_at[0], NG * K);
        check({tag, ":stall_errors"}, stall_err, 0);
        if (mode == 3) begin
            check({tag, ":result_count"}, results.size(), NG);
            for (int g = 0; g < NG && g < results.size(); g++) begin
                sum = 0;
                for (int t = 0; t < K; t++)
                    sum += int'(frame[g+t]) * int'(w_model[t]);
                if (results[g] != sum) rbad++;
            end
            check({tag, ":result_errors"}, rbad, 0);
        end
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{0, 100, 0, 0, 1'b1, 12'd1, 12'd1, 12'd32, 12'd5};
        tbl[1] = '{1, 100, 0, 3, 1'b1, 12'd1, 12'd1, 12'd32, 12'd5};
        tbl[2] = '{0, 100, 0, 3, 1'b1, 12'd1, 12'd1, 12'd32, 12'd5};
        tbl[3] = '{2, 60,  0, 3, 1'b1, 12'd1, 12'd1, 12'd32, 12'd5};
        tbl[4] = '{2, 50,  1, 1, 1'b0, 12'd0, 12'd0, 12'd0,  12'd0};
        tbl[5] = '{3, 100, 2, 2, 1'b1, 12'd2, 12'd1, 12'd2,  12'd1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset:ready_in", int'(ready_in), 1);
        check("reset:valid_out", int'(valid_out), 0);
        check("reset:dataa", int'(dataa), 0);
        check("reset:datab", int'(datab), 0);
        check("reset:frame_done", int'(frame_done), 0);
        check("reset:weight_wr_ready", int'(weight_wr_ready), 1);

        for (int v = 0; v < 6; v++) begin
            load_weights(tbl[v].w_kind);
            build_src(tbl[v].seq_kind, 0);
            run_frame(tbl[v].ready_mode, tbl[v].valid_pct, 0, 1'b0);
            check_frame($sformatf("vec%0d", v), tbl[v].ready_mode);
            if (tbl[v].check_ends && got_a.size() > 0) begin
                check($sformatf("vec%0d:first_a", v), int'(got_a[0]), int'(tbl[v].fa));
                check($sformatf("vec%0d:first_b", v), int'(got_b[0]), int'(tbl[v].fb));
                check($sformatf("vec%0d:last_a", v), int'(got_a[$]), int'(tbl[v].la));
                check($sformatf("vec%0d:last_b", v), int'(got_b[$]), int'(tbl[v].lb));
            end
        end

        load_weights(0);
        build_src(0, 0);
        run_frame(0, 100, 0, 1'b1);
        check_frame("wr_during_issue", 0);

        write_weight(3'd7, 77);
        write_weight(3'd2, 9);
        w_model[2] = 9;
        build_src(0, 200);
        run_frame(2, 80, 0, 1'b0);
        check_frame("wr_idle", 2);
        if (got_b.size() > 2)
            check("wr_idle:k2_weight", int'(got_b[2]), 9);

        load_weights(0);
        build_src(0, 0);
        run_frame(0, 100, 18, 1'b0);
        check("pre_reset:pairs", got_a.size(), 18);
        if (got_a.size() == 18) begin
            check("pre_reset:pair18_a", int'(got_a[17]), 6);
            check("pre_reset:pair18_b", int'(got_b[17]), 3);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset:valid_out", int'(valid_out), 0);
        check("mid_reset:ready_in", int'(ready_in), 1);
        check("mid_reset:weight_wr_ready", int'(weight_wr_ready), 1);
        load_weights(0);
        build_src(0, 100);
        run_frame(1, 100, 0, 1'b0);
        check_frame("after_reset", 1);
        if (got_a.size() > 0)
            check("after_reset:first_a", int'(got_a[0]), 101);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
